data_sram_slave: RTL and testbench
==================================

Name: data_sram_slave

Overview:
Responder end of the CPU data-side request/acknowledge interface. It accepts requests from the memory stage via data_req/data_addr_ok and performs byte-masked writes into an internal word-addressed RAM. It returns an in-order, fixed-latency data_data_ok/data_rdata response for every accepted request. It serves as the simulation and FPGA data memory behind the pipeline, and limits the number of outstanding requests through back-pressure on data_addr_ok.

Parameters:
ADDR_W, 10, word-address width; RAM holds 2^ADDR_W 32-bit words.
LATENCY, 2, cycles from the acceptance cycle to the data_data_ok cycle; legal range 1..8.
MAX_OUTST, 4, maximum outstanding requests (accepted, not yet acknowledged); legal range 1..8.

Ports:
clk  in  1  clock, rising edge.
resetn  in  1  asynchronous active-low reset.
data_req  in  1  request valid.
data_wr  in  1  1 = write, 0 = read.
data_wstrb  in  4  byte write enables; bit i covers data_wdata[8i+7:8i]; ignored for reads.
data_addr  in  32  byte address.
data_wdata  in  32  write data, already lane-aligned by the requester.
data_addr_ok  out  1  request accepted this cycle when high together with data_req.
data_data_ok  out  1  one-cycle response pulse, one per accepted request.
data_rdata  out  32  read data, valid while data_data_ok is high.
busy  out  1  high while at least one request is outstanding.

Behaviour:
- Clock and reset: clk is the single clock. resetn is asynchronous and active-low.
- Reset values: outstanding count = 0, all delay-line valid bits = 0, data_data_ok = 0, data_rdata = 0, busy = 0.
- data_addr_ok = resetn && (count < MAX_OUTST). It is combinational and does not depend on data_req or on a same-cycle data_data_ok.
- Accept: the cycle with data_req && data_addr_ok is cycle 0. At most one request is accepted per cycle.
- Word index: data_addr[ADDR_W+1:2]. Bits [1:0] are ignored. Upper bits are ignored, so addresses alias modulo 2^(ADDR_W+2).
- Write: at the end of cycle 0, the RAM word updates only in the bytes whose data_wstrb bit is 1. data_wstrb = 0000 is legal; it leaves the RAM unchanged and is still acknowledged.
- Read: data is sampled from the RAM at the end of cycle 0. It reflects every write accepted in earlier cycles and none accepted later.
- Response timing:
  - Every accepted request enters a LATENCY-deep delay line holding {valid, is_read, rdata}.
  - data_data_ok is high exactly in cycle LATENCY and for one cycle only.
  - Responses are in acceptance order.
  - data_rdata carries the sampled word for reads and 32'h0 for writes. data_rdata is 32'h0 whenever data_data_ok is low.
- Outstanding count:
  - +1 at the end of an accept cycle; -1 at the end of a data_data_ok cycle.
  - If both happen in the same cycle, the count is unchanged.
  - The count never exceeds MAX_OUTST and never underflows.
- busy = (count != 0).
- Throughput:
  - With MAX_OUTST >= LATENCY+1, one request per cycle is sustained.
  - With MAX_OUTST = 1, accepts are spaced LATENCY+1 cycles apart.
- Reset mid-operation: all in-flight responses are discarded, with no data_data_ok after reset. Writes already accepted remain in the RAM. RAM contents are not reset.
- data_req while data_addr_ok is low: no effect. The requester holds its request.
- X-safety: data_wr, data_wstrb, data_addr and data_wdata are only sampled in accept cycles.

Test Plan:
- Basic write/read, LATENCY=2: write 0x1000 = 0xDEADBEEF with wstrb 1111 in cycle 0 -> data_data_ok in cycle 2 with rdata 0. Then read 0x1000 in cycle 3 -> data_data_ok in cycle 5 with rdata 0xDEADBEEF.
- Byte strobes: starting from 0xDEADBEEF, write 0x1002 with data 0x00AA0000 and wstrb 0100, then read 0x1000 -> 0xDEAABEEF. A write with wstrb 0000 followed by a read -> still 0xDEAABEEF.
- Streaming, LATENCY=2, MAX_OUTST=4: data_req held high for 6 reads of consecutive words -> data_addr_ok high in every cycle, data_data_ok high in cycles 2-7, rdata returned in request order, busy low from cycle 8.
- Back-pressure, LATENCY=2, MAX_OUTST=1: data_req held high -> accepts in cycles 0, 3 and 6, data_data_ok in cycles 2, 5 and 8, data_addr_ok low in cycles 1-2 and 4-5.
- Reset mid-flight: accept a read in cycle 0 and assert resetn low during cycle 1 -> data_data_ok stays 0, count = 0 and data_addr_ok = 1 after resetn is released. A write accepted before the reset is still readable.
- Aliasing, ADDR_W=10: write 0x0000_0004 = 0x11223344, then read 0x0000_1004 and 0xFFFF_F007 -> both return 0x11223344.

Source files
------------

// File: rtl/data_sram_slave_if.sv
// rtl/data_sram_slave_if.sv - request/acknowledge bus between the memory stage and the data SRAM
interface data_sram_slave_if;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        busy;

  modport master (
    output data_req, data_wr, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata, busy
  );

  modport slave (
    input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata, busy
  );
endinterface

// File: rtl/data_sram_slave.sv
// rtl/data_sram_slave.sv - byte-masked word RAM with fixed-latency in-order responses
module data_sram_slave #(
  parameter int ADDR_W    = 10,
  parameter int LATENCY   = 2,
  parameter int MAX_OUTST = 4
) (
  input  logic              clk,
  input  logic              resetn,
  data_sram_slave_if.slave  bus
);
  localparam int CNT_W = 4;

  logic [31:0]        ram [2**ADDR_W];
  logic [CNT_W-1:0]   count;
  logic [LATENCY-1:0] dly_vld;
  logic [31:0]        dly_data [LATENCY];
  logic [ADDR_W-1:0]  idx;
  logic               accept;
  logic               retire;
  logic               unused_addr_bits;

  assign idx              = bus.data_addr[ADDR_W+1:2];
  assign unused_addr_bits = ^{bus.data_addr[31:ADDR_W+2], bus.data_addr[1:0]};

  assign bus.data_addr_ok = resetn && (count < CNT_W'(MAX_OUTST));
  assign accept           = bus.data_req && bus.data_addr_ok;
  assign retire           = dly_vld[LATENCY-1];
  assign bus.data_data_ok = retire;
  assign bus.data_rdata   = dly_data[LATENCY-1];
  assign bus.busy         = (count != '0);

  // RAM contents survive reset; only accepted writes touch them
  always_ff @(posedge clk) begin
    if (accept && bus.data_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.data_wstrb[b]) begin
          ram[idx][8*b +: 8] <= bus.data_wdata[8*b +: 8];
        end
      end
    end
  end

  // Delay-line data is forced to zero for writes and empty slots, so rdata is 0 whenever data_ok is low
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count   <= '0;
      dly_vld <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        dly_data[i] <= '0;
      end
    end else begin
      case ({accept, retire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      dly_vld[0]  <= accept;
      dly_data[0] <= (accept && !bus.data_wr) ? ram[idx] : 32'h0;
      for (int i = 1; i < LATENCY; i++) begin
        dly_vld[i]  <= dly_vld[i-1];
        dly_data[i] <= dly_data[i-1];
      end
    end
  end
endmodule

// File: tb/tb_data_sram_slave.sv
// tb/tb_data_sram_slave.sv - randomized bench for data_sram_slave against a queue-based response model
module tb_data_sram_slave;
  localparam int LATENCY   = 2;
  localparam int MAX_OUTST = 4;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  logic clk;
  logic resetn;
  int   total;
  int   bad;
  int   cyc;

  logic [31:0] mem [1024];
  rsp_t        q [$];

  data_sram_slave_if bus0 ();
  data_sram_slave_if bus1 ();

  data_sram_slave #(.ADDR_W(10), .LATENCY(LATENCY), .MAX_OUTST(MAX_OUTST)) u_dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus0)
  );

  data_sram_slave #(.ADDR_W(10), .LATENCY(2), .MAX_OUTST(1)) u_dut_bp (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  // One bus cycle: drive, check outputs at negedge against the model, then commit the model
  task automatic cycle(input logic req, input logic wr, input logic [3:0] strb,
                       input logic [31:0] addr, input logic [31:0] wd);
    logic        exp_aok;
    logic        exp_ok;
    logic [31:0] exp_rd;
    logic [9:0]  widx;
    bus0.data_req   = req;
    bus0.data_wr    = wr;
    bus0.data_wstrb = strb;
    bus0.data_addr  = addr;
    bus0.data_wdata = wd;
    @(negedge clk);
    exp_aok = (q.size() < MAX_OUTST);
    exp_ok  = (q.size() > 0) && (q[0].due == cyc);
    exp_rd  = exp_ok ? q[0].data : 32'h0;
    check_eq("addr_ok", 32'(bus0.data_addr_ok), 32'(exp_aok));
    check_eq("data_ok", 32'(bus0.data_data_ok), 32'(exp_ok));
    check_eq("rdata",   bus0.data_rdata, exp_rd);
    check_eq("busy",    32'(bus0.busy), 32'(q.size() != 0));
    if (exp_ok) void'(q.pop_front());
    if (req && exp_aok) begin
      widx = addr[11:2];
      if (wr) begin
        for (int b = 0; b < 4; b++) begin
          if (strb[b]) mem[widx][8*b +: 8] = wd[8*b +: 8];
        end
        q.push_back('{cyc + LATENCY, 32'h0});
      end else begin
        q.push_back('{cyc + LATENCY, mem[widx]});
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic reset_cycle();
    bus0.data_req = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    check_eq("rst_addr_ok", 32'(bus0.data_addr_ok), 32'h0);
    check_eq("rst_data_ok", 32'(bus0.data_data_ok), 32'h0);
    check_eq("rst_rdata",   bus0.data_rdata, 32'h0);
    check_eq("rst_busy",    32'(bus0.busy), 32'h0);
    q.delete();
    resetn = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    logic [8:0] aok_pat;
    logic [8:0] ok_pat;
    total = 0;
    bad   = 0;
    cyc   = 0;
    resetn = 1'b0;
    bus0.data_req = 1'b0; bus0.data_wr = 1'b0; bus0.data_wstrb = 4'h0;
    bus0.data_addr = 32'h0; bus0.data_wdata = 32'h0;
    bus1.data_req = 1'b0; bus1.data_wr = 1'b0; bus1.data_wstrb = 4'h0;
    bus1.data_addr = 32'h0; bus1.data_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_data_ok", 32'(bus0.data_data_ok), 32'h0);
    check_eq("reset_rdata",   bus0.data_rdata, 32'h0);
    check_eq("reset_busy",    32'(bus0.busy), 32'h0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // basic write then read
    cycle(1'b1, 1'b1, 4'hF, 32'h0000_1000, 32'hDEADBEEF);
    idle(2);
    cycle(1'b1, 1'b0, 4'h0, 32'h0000_1000, 32'h0);
    idle(3);

    // byte strobes, including an empty strobe
    cycle(1'b1, 1'b1, 4'b0100, 32'h0000_1002, 32'h00AA_0000);
    cycle(1'b1, 1'b0, 4'h0, 32'h0000_1000, 32'h0);
    cycle(1'b1, 1'b1, 4'b0000, 32'h0000_1000, 32'hFFFF_FFFF);
    cycle(1'b1, 1'b0, 4'h0, 32'h0000_1000, 32'h0);
    idle(3);

    // aliasing of upper and low address bits
    cycle(1'b1, 1'b1, 4'hF, 32'h0000_0004, 32'h1122_3344);
    cycle(1'b1, 1'b0, 4'h0, 32'h0000_1004, 32'h0);
    cycle(1'b1, 1'b0, 4'h0, 32'hFFFF_F007, 32'h0);
    idle(3);

    // streaming reads of consecutive words
    for (int i = 1; i < 6; i++) cycle(1'b1, 1'b1, 4'hF, 32'h1000 + 32'(4*i), $urandom);
    idle(3);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 4'h0, 32'h1000 + 32'(4*i), 32'h0);
    idle(4);

    // reset while a read is in flight
    cycle(1'b1, 1'b1, 4'hF, 32'h0000_2000, 32'hCAFE_F00D);
    idle(3);
    cycle(1'b1, 1'b0, 4'h0, 32'h0000_2000, 32'h0);
    reset_cycle();
    idle(3);
    cycle(1'b1, 1'b0, 4'h0, 32'h0000_2000, 32'h0);
    idle(3);

    // single-outstanding instance under continuous request
    aok_pat = 9'b001001001;
    ok_pat  = 9'b100100100;
    for (int i = 0; i < 9; i++) begin
      bus1.data_req = 1'b1;
      @(negedge clk);
      check_eq("bp_addr_ok", 32'(bus1.data_addr_ok), 32'(aok_pat[i]));
      check_eq("bp_data_ok", 32'(bus1.data_data_ok), 32'(ok_pat[i]));
      @(posedge clk);
      #1;
    end
    bus1.data_req = 1'b0;
    idle(4);

    // fill every word, then random traffic
    for (int i = 0; i < 1024; i++) cycle(1'b1, 1'b1, 4'hF, 32'(i) << 2, $urandom);
    idle(4);
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(3) != 0), 1'($urandom_range(1)), 4'($urandom),
            $urandom, $urandom);
    end
    idle(LATENCY + 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
